// File: rtl/uart_tx_capture.sv
// UART 8N1 receiver with a first-word-fall-through byte FIFO and sticky error flags.
// Define UART_CAPTURE_PARITY_EN to add an even-parity bit and the io_parity_err output.
module uart_tx_capture #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          io_rx,
    input  logic                          io_clear,
    input  logic                          io_ready,
    output logic [7:0]                    io_data,
    output logic                          io_valid,
    output logic [$clog2(FIFO_DEPTH):0]   io_count,
    output logic                          io_frame_err,
    output logic                          io_overflow,
    output logic                          io_busy
`ifdef UART_CAPTURE_PARITY_EN
    ,
    output logic                          io_parity_err
`endif
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
`ifdef UART_CAPTURE_PARITY_EN
        PARITY = 3'd5,
`endif
        BREAK  = 3'd4
    } state_t;

    state_t        state;
    logic          rx_m, rx_s, rx_p;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          tick, fall, push_req, frame_set;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, pop, do_push;

    assign tick      = (timer == '0);
    assign fall      = rx_p & ~rx_s;
    assign push_req  = (state == STOP) && tick && rx_s;
    assign frame_set = (state == STOP) && tick && !rx_s;

    assign full     = (count == (AW + 1)'(FIFO_DEPTH));
    assign io_valid = (count != '0);
    assign pop      = io_valid && io_ready;
    // A full FIFO still takes the byte when the head leaves in the same cycle.
    assign do_push  = push_req && (!full || pop);

    assign io_count = count;
    assign io_data  = io_valid ? mem[rd_ptr] : 8'h00;
    assign io_busy  = (state != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_p <= 1'b1;
        end else begin
            rx_m <= io_rx;
            rx_s <= rx_m;
            rx_p <= rx_s;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            timer        <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            io_frame_err <= 1'b0;
`ifdef UART_CAPTURE_PARITY_EN
            io_parity_err <= 1'b0;
`endif
        end else begin
            io_frame_err <= frame_set | (io_frame_err & ~io_clear);
`ifdef UART_CAPTURE_PARITY_EN
            io_parity_err <= ((state == PARITY) && tick && (rx_s != ^shift))
                             | (io_parity_err & ~io_clear);
`endif
            if (!tick) timer <= timer - 1'b1;
            case (state)
                IDLE: begin
                    if (fall) begin
                        state <= START;
                        timer <= HALF;
                    end
                end
                START: begin
                    if (tick) begin
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            timer   <= FULL;
                            bit_idx <= '0;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift   <= {rx_s, shift[7:1]};
                        timer   <= FULL;
                        bit_idx <= bit_idx + 1'b1;
`ifdef UART_CAPTURE_PARITY_EN
                        if (bit_idx == 3'd7) state <= PARITY;
`else
                        if (bit_idx == 3'd7) state <= STOP;
`endif
                    end
                end
`ifdef UART_CAPTURE_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        timer <= FULL;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    // Leaving at mid-stop-bit lets the next start edge follow with no gap.
                    if (tick) state <= rx_s ? IDLE : BREAK;
                end
                BREAK: begin
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            io_overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !pop)      count <= count + 1'b1;
            else if (pop && !do_push) count <= count - 1'b1;
            io_overflow <= (push_req && full && !pop) | (io_overflow & ~io_clear);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= shift;
    end

endmodule

// File: tb/tb_uart_tx_capture.sv
// Randomized bench for uart_tx_capture: serial frames are driven bit by bit and the
// received bytes and flags are compared against a queue model of the FIFO.
module tb_uart_tx_capture;
    localparam int CPB   = 8;
    localparam int DEPTH = 8;
`ifdef UART_CAPTURE_PARITY_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif
    localparam int LAT = 2 + CPB / 2 + NB * CPB + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       io_rx, io_clear, io_ready;
    logic [7:0] io_data;
    logic       io_valid, io_frame_err, io_overflow, io_busy;
    logic [3:0] io_count;
`ifdef UART_CAPTURE_PARITY_EN
    logic       io_parity_err;
    logic       par_bad = 1'b0;
    bit         par_m = 1'b0;
`endif

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q[$];
    bit         ovf_m = 1'b0;
    bit         frm_m = 1'b0;

    uart_tx_capture #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clock        (clk),
        .reset        (rst),
        .io_rx        (io_rx),
        .io_clear     (io_clear),
        .io_ready     (io_ready),
        .io_data      (io_data),
        .io_valid     (io_valid),
        .io_count     (io_count),
        .io_frame_err (io_frame_err),
        .io_overflow  (io_overflow),
        .io_busy      (io_busy)
`ifdef UART_CAPTURE_PARITY_EN
        ,
        .io_parity_err(io_parity_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: got=timeout exp=finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bit_out(input logic v, input int n);
        io_rx = v;
        step(n);
    endtask

    // stop_low = 0 sends a good stop bit, otherwise the line stays low that many bit times.
    task automatic send_frame(input logic [7:0] b, input int stop_low);
        bit_out(1'b0, CPB);
        for (int i = 0; i < 8; i++) bit_out(b[i], CPB);
`ifdef UART_CAPTURE_PARITY_EN
        bit_out((^b) ^ par_bad, CPB);
`endif
        if (stop_low > 0) begin
            bit_out(1'b0, CPB * stop_low);
            bit_out(1'b1, CPB);
        end else begin
            bit_out(1'b1, CPB);
        end
    endtask

    task automatic model_frame(input logic [7:0] b, input int stop_low);
`ifdef UART_CAPTURE_PARITY_EN
        if (par_bad) par_m = 1'b1;
`endif
        if (stop_low > 0) frm_m = 1'b1;
        else if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else ovf_m = 1'b1;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"}, 32'(io_count), 32'(exp_q.size()));
        check({tag, "_valid"}, 32'(io_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() > 0) check({tag, "_head"}, 32'(io_data), 32'(exp_q[0]));
        check({tag, "_ovf"}, 32'(io_overflow), 32'(ovf_m));
        check({tag, "_frm"}, 32'(io_frame_err), 32'(frm_m));
`ifdef UART_CAPTURE_PARITY_EN
        check({tag, "_par"}, 32'(io_parity_err), 32'(par_m));
`endif
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while (exp_q.size() > 0 && guard < 64) begin
            check({tag, "_pop"}, 32'(io_data), 32'(exp_q[0]));
            io_ready = 1'b1;
            step(1);
            io_ready = 1'b0;
            void'(exp_q.pop_front());
            guard++;
        end
        check({tag, "_empty_cnt"}, 32'(io_count), 32'd0);
        check({tag, "_empty_vld"}, 32'(io_valid), 32'd0);
    endtask

    task automatic pulse_clear();
        io_clear = 1'b1;
        step(1);
        io_clear = 1'b0;
        ovf_m = 1'b0;
        frm_m = 1'b0;
`ifdef UART_CAPTURE_PARITY_EN
        par_m = 1'b0;
`endif
    endtask

    initial begin
        int n;
        bit seen;
        logic [7:0] b;
        int sl;

        io_rx = 1'b1;
        io_clear = 1'b0;
        io_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", 32'(io_data), 32'd0);
        check("rst_busy", 32'(io_busy), 32'd0);
        check_state("rst");
        rst = 1'b0;
        step(2);

        // single byte with exact start-edge-to-valid latency
        n = 0;
        seen = 1'b0;
        fork
            send_frame(8'hA5, 0);
            begin
                while (!seen && n < LAT + 50) begin
                    @(negedge clk);
                    if (io_valid) seen = 1'b1;
                    else n++;
                end
            end
        join
        check("t1_latency", 32'(n), 32'(LAT));
        model_frame(8'hA5, 0);
        check_state("t1");
        drain("t1");
        io_ready = 1'b1;
        step(2);
        io_ready = 1'b0;
        check("pop_empty_cnt", 32'(io_count), 32'd0);

        // back-to-back frames, no idle between stop and start
        send_frame(8'h00, 0);
        send_frame(8'hFF, 0);
        send_frame(8'h3C, 0);
        model_frame(8'h00, 0);
        model_frame(8'hFF, 0);
        model_frame(8'h3C, 0);
        check_state("t2");
        drain("t2");

        // two-cycle glitch is a false start
        bit_out(1'b0, 2);
        io_rx = 1'b1;
        step(1);
        check("t3_busy_start", 32'(io_busy), 32'd1);
        step(3);
        check("t3_busy_late", 32'(io_busy), 32'd1);
        step(1);
        check("t3_busy_idle", 32'(io_busy), 32'd0);
        check_state("t3");

        // stop held low: one frame error; clearing mid-break must not re-arm it
        fork
            send_frame(8'h55, 20);
            begin
                step(LAT + 5 * CPB);
                check("t4_frm_set", 32'(io_frame_err), 32'd1);
                check("t4_busy_brk", 32'(io_busy), 32'd1);
                pulse_clear();
                check("t4_frm_clr", 32'(io_frame_err), 32'd0);
            end
        join
        step(CPB);
        check("t4_busy_after", 32'(io_busy), 32'd0);
        check_state("t4");
        // clear coinciding with the stop-bit error: the set wins
        fork
            send_frame(8'h33, 2);
            begin
                step(LAT - 1);
                io_clear = 1'b1;
                step(1);
                io_clear = 1'b0;
                check("t4_set_dom", 32'(io_frame_err), 32'd1);
            end
        join
        model_frame(8'h33, 2);
        check_state("t4b");
        pulse_clear();
        check_state("t4c");

        // overflow drops the ninth byte
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 0);
            model_frame(8'(i), 0);
        end
        check_state("t5");
        pulse_clear();
        check_state("t5_clr");
        drain("t5");
        // ninth byte with a pop in its push cycle is accepted
        for (int i = 1; i <= 8; i++) begin
            send_frame(8'(i), 0);
            model_frame(8'(i), 0);
        end
        fork
            send_frame(8'h09, 0);
            begin
                step(LAT - 1);
                check("t5b_head", 32'(io_data), 32'(exp_q[0]));
                io_ready = 1'b1;
                step(1);
                io_ready = 1'b0;
            end
        join
        void'(exp_q.pop_front());
        exp_q.push_back(8'h09);
        check_state("t5b");
        drain("t5b");

        // asynchronous reset in the middle of a frame
        send_frame(8'h42, 0);
        model_frame(8'h42, 0);
        check_state("t6_pre");
        bit_out(1'b0, CPB);
        bit_out(1'b1, CPB);
        bit_out(1'b0, CPB / 2);
        rst = 1'b1;
        #1;
        check("t6_rst_cnt", 32'(io_count), 32'd0);
        check("t6_rst_vld", 32'(io_valid), 32'd0);
        check("t6_rst_data", 32'(io_data), 32'd0);
        check("t6_rst_busy", 32'(io_busy), 32'd0);
        exp_q.delete();
        io_rx = 1'b1;
        step(2);
        rst = 1'b0;
        step(3 * CPB);
        send_frame(8'h7E, 0);
        model_frame(8'h7E, 0);
        check_state("t6");
        drain("t6");
`ifdef UART_CAPTURE_PARITY_EN
        par_bad = 1'b1;
        send_frame(8'h7E, 0);
        model_frame(8'h7E, 0);
        par_bad = 1'b0;
        check_state("t6_par");
        pulse_clear();
        check_state("t6_par_clr");
        drain("t6_par");
`endif

        // randomized bursts with occasional broken stop bits
        for (int r = 0; r < 5; r++) begin
            n = $urandom_range(1, 11);
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom_range(0, 255));
                sl = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
`ifdef UART_CAPTURE_PARITY_EN
                par_bad = ($urandom_range(0, 3) == 0);
`endif
                send_frame(b, sl);
                model_frame(b, sl);
                step($urandom_range(0, 12));
            end
`ifdef UART_CAPTURE_PARITY_EN
            par_bad = 1'b0;
`endif
            check_state($sformatf("rnd%0d", r));
            pulse_clear();
            check_state($sformatf("rnd%0d_clr", r));
            drain($sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
